// File: rtl/adc_pkg.sv
// Shared types and default sizing for the ADC sequencer slice.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RELEASE,
        ACCUM,
        EMIT
    } seq_state_t;

    localparam int DEFAULT_RESOLUTION = 4;
    localparam int DEFAULT_AVG_LOG2   = 2;

endpackage

// File: rtl/adc_sequencer_if.sv
// SAR start/ready handshake plus the averaged-result valid/ready stream.
interface adc_sequencer_if
    import adc_pkg::*;
#(
    parameter int RESOLUTION = DEFAULT_RESOLUTION
);

    logic                  adc_start_o;
    logic                  adc_rdy_i;
    logic [RESOLUTION-1:0] adc_result_i;
    logic [RESOLUTION-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;

    modport master (
        output adc_start_o,
        input  adc_rdy_i,
        input  adc_result_i,
        output data_o,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  adc_start_o,
        output adc_rdy_i,
        output adc_result_i,
        input  data_o,
        input  valid_o,
        output ready_i
    );

endinterface

// File: rtl/adc_tick_gen.sv
// Sample-period counter with a one-deep pending-tick latch; a tick that
// finds the latch already full is dropped and reported as an overrun pulse.
module adc_tick_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] period_i,
    input  logic                 consume_i,
    input  logic                 flush_i,
    output logic                 tickPend_o,
    output logic                 tickOverrun_o
);

    logic [DIV_WIDTH-1:0] count_q, count_d;
    logic                 tickPend_q, tickPend_d;
    logic                 tick;

    // Wrap on >= so a period shortened mid-count cannot run away to all-ones.
    always_comb begin
        tick       = en_i && (count_q >= period_i);
        count_d    = '0;
        tickPend_d = tickPend_q;
        if (en_i && !tick) begin
            count_d = count_q + 1'b1;
        end
        if (flush_i || consume_i) begin
            tickPend_d = 1'b0;
        end else if (tick) begin
            tickPend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= '0;
            tickPend_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tickPend_q <= tickPend_d;
        end
    end

    assign tickPend_o    = tickPend_q;
    assign tickOverrun_o = tick && tickPend_q;

endmodule

// File: rtl/adc_sequencer.sv
// Periodic SAR conversion sequencer: drives the start/ready handshake,
// averages 2^AVG_LOG2 results and offers the average on a valid/ready stream.
module adc_sequencer
    import adc_pkg::*;
#(
    parameter int RESOLUTION = DEFAULT_RESOLUTION,
    parameter int AVG_LOG2   = DEFAULT_AVG_LOG2,
    parameter int DIV_WIDTH  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] period_i,
    input  logic                 clear_i,
    adc_sequencer_if.master      bus,
    output logic                 overrun_o,
    output logic                 timeout_o,
    output logic                 busy_o
);

    localparam int ACC_W  = RESOLUTION + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT - 1);

    seq_state_t            state_q;
    logic                  start_q, valid_q, busy_q, overrun_q, timeout_q;
    logic [RESOLUTION-1:0] data_q, result_q;
    logic [ACC_W-1:0]      acc_q;
    logic [CNT_W-1:0]      sampleCnt_q;
    logic [WAIT_W-1:0]     waitCnt_q;
    logic                  tickPend, tickOverrun, consume, flush;

    assign consume = (state_q == IDLE) && en_i && tickPend;
    assign flush   = (state_q == IDLE) && !en_i;

    adc_tick_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick_gen (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .period_i     (period_i),
        .consume_i    (consume),
        .flush_i      (flush),
        .tickPend_o   (tickPend),
        .tickOverrun_o(tickOverrun)
    );

    // Sticky flags are cleared first so a same-cycle set event overrides the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            data_q      <= '0;
            result_q    <= '0;
            acc_q       <= '0;
            sampleCnt_q <= '0;
            waitCnt_q   <= '0;
        end else begin
            if (clear_i) begin
                overrun_q <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (tickOverrun) begin
                overrun_q <= 1'b1;
            end
            if (valid_q && bus.ready_i) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (!en_i) begin
                        acc_q       <= '0;
                        sampleCnt_q <= '0;
                    end else if (tickPend) begin
                        state_q   <= START;
                        start_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        waitCnt_q <= '0;
                    end
                end
                START, RELEASE: begin
                    if (state_q == START && bus.adc_rdy_i) begin
                        state_q   <= RELEASE;
                        start_q   <= 1'b0;
                        waitCnt_q <= '0;
                    end else if (state_q == RELEASE && !bus.adc_rdy_i) begin
                        state_q  <= ACCUM;
                        result_q <= bus.adc_result_i;
                    end else if (waitCnt_q == WAIT_LAST) begin
                        state_q     <= IDLE;
                        start_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        timeout_q   <= 1'b1;
                        acc_q       <= '0;
                        sampleCnt_q <= '0;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_q + ACC_W'(result_q);
                    if (sampleCnt_q == LAST_SAMPLE) begin
                        sampleCnt_q <= '0;
                        state_q     <= EMIT;
                    end else begin
                        sampleCnt_q <= sampleCnt_q + 1'b1;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                EMIT: begin
                    if (!valid_q || bus.ready_i) begin
                        data_q  <= RESOLUTION'(acc_q >> AVG_LOG2);
                        valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                    acc_q   <= '0;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.adc_start_o = start_q;
    assign bus.data_o      = data_q;
    assign bus.valid_o     = valid_q;
    assign overrun_o       = overrun_q;
    assign timeout_o       = timeout_q;
    assign busy_o          = busy_q;

endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
- Control and post-processing stage that sits directly in front of the SAR conversion FSM.
- Generates periodic conversion requests on the SAR's start line and completes the start/ready handshake.
- Captures each conversion result, averages 2^AVG_LOG2 results, and presents the average on a valid/ready stream to the digital back end.

Parameters:
RESOLUTION, 4, SAR result width in bits.
AVG_LOG2, 2, log2 of the number of conversions averaged per output word (0 = no averaging).
DIV_WIDTH, 16, width of the sample-period counter.
TIMEOUT, 64, maximum cycles to wait for a SAR ready edge before aborting.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
en_i  in  1  enable periodic conversions
period_i  in  DIV_WIDTH  sample period in clk cycles, minus 1
adc_start_o  out  1  start request to the SAR FSM
adc_rdy_i  in  1  SAR done/ready flag
adc_result_i  in  RESOLUTION  SAR result; valid from the cycle adc_rdy_i falls after start is released
data_o  out  RESOLUTION  averaged result
valid_o  out  1  data_o valid
ready_i  in  1  downstream accepts data_o
overrun_o  out  1  sticky: average dropped or tick missed
timeout_o  out  1  sticky: SAR handshake timeout
clear_i  in  1  synchronous clear of the sticky flags
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; counters, accumulator, pending tick and state cleared; state IDLE.
- Tick generator:
  - Counts 0..period_i while en_i=1, then wraps.
  - Pulses tick for one cycle at terminal count.
  - period_i=0 gives a tick every cycle.
  - en_i=0 holds the count at 0.
- Pending tick:
  - A tick sets tick_pend.
  - A tick arriving while tick_pend=1 sets overrun_o; the tick is dropped and tick_pend stays 1.
  - tick_pend is consumed on the IDLE->START transition.
- FSM states (enum):
  - IDLE: if en_i && tick_pend -> START. adc_start_o=0.
  - START: adc_start_o=1. When adc_rdy_i=1 -> RELEASE.
  - RELEASE: adc_start_o=0. When adc_rdy_i=0 -> ACCUM, capturing adc_result_i that cycle. The result is valid as rdy falls.
  - ACCUM (1 cycle):
    - acc += result; increment sample count.
    - If count wraps to 0, the average is complete: go to EMIT.
    - Otherwise -> IDLE.
  - EMIT (1 cycle):
    - If valid_o=0 or ready_i=1: load data_o = acc >> AVG_LOG2 (truncate) and set valid_o=1.
    - Otherwise drop the average and set overrun_o.
    - Clear acc. -> IDLE.
- Widths: acc is RESOLUTION+AVG_LOG2 bits, so it never overflows. The sample count is AVG_LOG2 bits; with AVG_LOG2=0 every sample emits.
- Output handshake:
  - data_o/valid_o hold until valid_o && ready_i, which clears valid_o on the next edge.
  - Accept and new load in the same cycle: the new load wins, so valid_o stays 1.
- Timeout:
  - The wait counter resets on entry to START and RELEASE.
  - If TIMEOUT cycles pass without the awaited rdy level: set timeout_o, drop adc_start_o, discard the sample, clear acc and sample count, go to IDLE.
- en_i falling:
  - No new START is issued.
  - An in-flight START/RELEASE/ACCUM/EMIT sequence completes normally.
  - When in IDLE with en_i=0: acc, sample count and tick_pend are cleared. A partial average is discarded without setting a flag.
- clear_i clears overrun_o and timeout_o. If a set event occurs in the same cycle, set wins.
- Reset mid-handshake drops adc_start_o immediately (asynchronous).

Decomposition:
- Package adc_pkg:
  - seq_state_t enum {IDLE, START, RELEASE, ACCUM, EMIT}.
  - Default constants for RESOLUTION and AVG_LOG2.
- Sub-module adc_tick_gen: period counter, tick pulse and the pending/overrun tick logic.

Test Plan:
- AVG_LOG2=0, period_i=9, SAR model returns 0xA, ready_i=1 -> adc_start_o rises every 10 cycles; data_o=0xA with a 1-cycle valid_o per conversion.
- AVG_LOG2=2, results 3,4,5,6 -> a single valid_o with data_o=4 (18>>2). Results 15,15,15,15 -> data_o=15, no wrap.
- ready_i=0 held across two completed averages -> first data_o kept, overrun_o=1; clear_i pulse -> overrun_o=0.
- period_i=0 with a SAR that takes 8 cycles -> missed ticks set overrun_o; conversions run back-to-back with no duplicate START.
- SAR never raises rdy -> after 64 cycles adc_start_o=0 and timeout_o=1; FSM returns to IDLE and next tick restarts normally.
- Deassert en_i mid-RELEASE, and separately assert rst_ni=0 in START -> handshake completes and the FSM idles; reset forces all outputs to 0 asynchronously.
